// File: rtl/system_supervisor_pkg.sv
// Shared types and register map for the multi-core system supervisor.
package system_supervisor_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StReady    = 3'd1,
    StRunning  = 3'd2,
    StDraining = 3'd3,
    StHalted   = 3'd4,
    StTimeout  = 3'd5
  } supervisor_state_t;

  localparam int unsigned MmioAddrWidth = 8;
  localparam int unsigned MmioDataWidth = 32;

  localparam logic [MmioAddrWidth-1:0] RegControl   = 8'd0;
  localparam logic [MmioAddrWidth-1:0] RegStatus    = 8'd1;
  localparam logic [MmioAddrWidth-1:0] RegCycleLo   = 8'd2;
  localparam logic [MmioAddrWidth-1:0] RegCycleHi   = 8'd3;
  localparam logic [MmioAddrWidth-1:0] RegWdogLimit = 8'd4;
  localparam logic [MmioAddrWidth-1:0] RegHaltMask  = 8'd5;

  localparam int unsigned CtrlResetBit   = 0;
  localparam int unsigned CtrlEnableBit  = 1;
  localparam int unsigned CtrlExecuteBit = 2;

endpackage

// File: rtl/mmio_if.sv
// Word-addressed register access leg: one request per cycle, read data returned one cycle later.
interface mmio_if;
  import system_supervisor_pkg::*;

  logic                     req;
  logic                     write;
  logic [MmioAddrWidth-1:0] addr;
  logic [MmioDataWidth-1:0] wdata;
  logic                     rvalid;
  logic [MmioDataWidth-1:0] rdata;

  modport device (input req, write, addr, wdata, output rvalid, rdata);
  modport host   (output req, write, addr, wdata, input rvalid, rdata);
endinterface

// File: rtl/quiescence_detector.sv
// Masks and reduces the per-core/per-memory quiescent vectors and requires HOLD consecutive
// quiet cycles before reporting quiet_stable.
module quiescence_detector #(
  parameter int unsigned NUM_CORES    = 4,
  parameter int unsigned NUM_MEMORIES = 1,
  parameter int unsigned HOLD         = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic [NUM_CORES-1:0]    core_mask,
  input  logic [NUM_CORES-1:0]    channels_quiescent,
  input  logic [NUM_CORES-1:0]    routers_quiescent,
  input  logic [NUM_MEMORIES-1:0] memories_quiescent,
  output logic                    quiet_stable
);

  localparam int unsigned HoldW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD - 1);

  logic             chan_quiet, rout_quiet, mem_quiet, quiet;
  logic [HoldW-1:0] hold_q, hold_d;

  assign chan_quiet = &(channels_quiescent | ~core_mask);
  assign rout_quiet = &(routers_quiescent | ~core_mask);
  assign mem_quiet  = &memories_quiescent;
  assign quiet      = chan_quiet & rout_quiet & mem_quiet;

  // hold_q counts completed quiet cycles; the current quiet cycle makes the HOLD-th.
  assign quiet_stable = quiet && (hold_q == HoldLast);

  always_comb begin
    hold_d = hold_q;
    if (clear || !quiet) begin
      hold_d = '0;
    end else if (hold_q != HoldLast) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/multi_core_system_supervisor.sv
// Run-control supervisor for an N-core array: MMIO control, halt/quiescence detection, cycle count.
// Optional watchdog timeout enabled by defining SYSTEM_SUPERVISOR_WATCHDOG_EN.
module multi_core_system_supervisor
  import system_supervisor_pkg::*;
#(
  parameter int unsigned NUM_CORES             = 4,
  parameter int unsigned NUM_MEMORIES          = 1,
  parameter int unsigned CYCLE_COUNTER_WIDTH   = 48,
  parameter int unsigned QUIESCENT_HOLD_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  mmio_if.device                  host_interface,
  output logic                    system_reset,
  output logic                    system_enable,
  output logic                    system_execute,
  output logic                    system_halted,
  input  logic [NUM_CORES-1:0]    core_halted,
  input  logic [NUM_CORES-1:0]    channels_quiescent,
  input  logic [NUM_CORES-1:0]    routers_quiescent,
  input  logic [NUM_MEMORIES-1:0] memories_quiescent
);

  localparam int unsigned CycleW = CYCLE_COUNTER_WIDTH;
  localparam int unsigned HiW    = CycleW - 32;

  supervisor_state_t        state_q, state_d;
  logic [CycleW-1:0]        counter_q, counter_d;
  logic [HiW-1:0]           cycle_hi_q, cycle_hi_d;
  logic [NUM_CORES-1:0]     mask_q, mask_d;
  logic                     enable_q, enable_d;
  logic                     rvalid_q;
  logic [MmioDataWidth-1:0] rdata_q, rdata_d;

  logic wr_en, rd_en, ctrl_wr, ctrl_reset, ctrl_run;
  logic all_halted, quiet_stable, wdog_hit, timed_out, run_entry;

  assign wr_en      = host_interface.req && host_interface.write;
  assign rd_en      = host_interface.req && !host_interface.write;
  assign ctrl_wr    = wr_en && (host_interface.addr == RegControl);
  assign ctrl_reset = ctrl_wr && host_interface.wdata[CtrlResetBit];
  assign ctrl_run   = ctrl_wr && host_interface.wdata[CtrlExecuteBit]
                      && host_interface.wdata[CtrlEnableBit];
  assign all_halted = &(core_halted | ~mask_q);

`ifdef SYSTEM_SUPERVISOR_WATCHDOG_EN
  logic [MmioDataWidth-1:0] wdog_q;

  assign wdog_hit = (wdog_q != '0) && (counter_q == CycleW'(wdog_q));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q <= '0;
    end else if (wr_en && (host_interface.addr == RegWdogLimit)) begin
      wdog_q <= host_interface.wdata;
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

  assign timed_out = (state_q == StTimeout);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (ctrl_wr && !host_interface.wdata[CtrlResetBit]) state_d = StReady;
      StReady:    if (ctrl_run) state_d = StRunning;
      StRunning: begin
        if (wdog_hit)        state_d = StTimeout;
        else if (all_halted) state_d = StDraining;
      end
      StDraining: begin
        if (wdog_hit)          state_d = StTimeout;
        else if (!all_halted)  state_d = StRunning;
        else if (quiet_stable) state_d = StHalted;
      end
      StHalted:   if (ctrl_run) state_d = StRunning;
      StTimeout:  state_d = StTimeout;
      default:    state_d = StIdle;
    endcase
    // A reset request overrides everything, including execute in the same write.
    if (ctrl_reset) state_d = StIdle;
  end

  assign run_entry = (state_d == StRunning) && ((state_q == StReady) || (state_q == StHalted));

  // Count only while staying in a run state, so the value freezes on the halting edge.
  always_comb begin
    counter_d = counter_q;
    if (state_d == StIdle || run_entry) begin
      counter_d = '0;
    end else if ((state_d == StRunning || state_d == StDraining) && counter_q != '1) begin
      counter_d = counter_q + 1'b1;
    end
  end

  always_comb begin
    enable_d = enable_q;
    mask_d   = mask_q;
    if (ctrl_wr) begin
      enable_d = host_interface.wdata[CtrlEnableBit] & ~host_interface.wdata[CtrlResetBit];
    end
    if (wr_en && (host_interface.addr == RegHaltMask)) begin
      mask_d = host_interface.wdata[NUM_CORES-1:0];
    end
  end

  always_comb begin
    rdata_d    = '0;
    cycle_hi_d = cycle_hi_q;
    if (rd_en) begin
      case (host_interface.addr)
        RegStatus:    rdata_d = MmioDataWidth'({timed_out, system_halted, state_q});
        RegCycleLo: begin
          rdata_d    = counter_q[31:0];
          cycle_hi_d = counter_q[CycleW-1:32];
        end
        RegCycleHi:   rdata_d = MmioDataWidth'(cycle_hi_q);
`ifdef SYSTEM_SUPERVISOR_WATCHDOG_EN
        RegWdogLimit: rdata_d = wdog_q;
`endif
        RegHaltMask:  rdata_d = MmioDataWidth'(mask_q);
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      counter_q  <= '0;
      cycle_hi_q <= '0;
      mask_q     <= '1;
      enable_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      cycle_hi_q <= cycle_hi_d;
      mask_q     <= mask_d;
      enable_q   <= enable_d;
      rvalid_q   <= rd_en;
      rdata_q    <= rdata_d;
    end
  end

  quiescence_detector #(
    .NUM_CORES    (NUM_CORES),
    .NUM_MEMORIES (NUM_MEMORIES),
    .HOLD         (QUIESCENT_HOLD_CYCLES)
  ) u_quiescence_detector (
    .clock              (clock),
    .reset_n            (reset_n),
    .clear              ((state_q != StDraining) || (state_d != StDraining)),
    .core_mask          (mask_q),
    .channels_quiescent (channels_quiescent),
    .routers_quiescent  (routers_quiescent),
    .memories_quiescent (memories_quiescent),
    .quiet_stable       (quiet_stable)
  );

  assign host_interface.rvalid = rvalid_q;
  assign host_interface.rdata  = rdata_q;

  assign system_reset   = (state_q == StIdle);
  assign system_enable  = enable_q;
  assign system_execute = (state_q == StRunning) || (state_q == StDraining);
  assign system_halted  = (state_q == StHalted) || (state_q == StTimeout);

endmodule
